// File: rtl/harness_pkg.sv
// Shared definitions for the post-execution harness: controller states and the
// instruction word that marks program termination.
package harness_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DUMP,
        ST_DONE
    } dump_state_t;

    localparam logic [31:0] HALT_WORD = 32'h0;

endpackage

// File: rtl/halt_dump_controller.sv
// Watches the fetch bus for the halt word, lets in-flight stores drain, then
// streams every data-memory word out through a back-pressurable valid/ready port.
module halt_dump_controller
    import harness_pkg::*;
#(
    parameter int MEM_WORDS    = 2048,
    parameter int DRAIN_CYCLES = 19,
    parameter int IDX_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction_memory_rd,
    output logic [IDX_W-1:0]  dump_a,
    output logic              dump_sel,
    input  logic [31:0]       data_memory_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [31:0]       out_data,
    output logic              halted,
    output logic              done
);

    // rd_idx carries one extra bit so MEM_WORDS == 2^IDX_W cannot wrap to zero.
    localparam logic [IDX_W:0] MEM_END    = (IDX_W+1)'(MEM_WORDS);
    localparam logic [31:0]    DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

    dump_state_t      state;
    dump_state_t      state_next;
    logic [31:0]      drain_cnt;
    logic [IDX_W:0]   rd_idx;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_index_q;
    logic [31:0]      out_data_q;
    logic             halted_q;
    logic             halt_seen;
    logic             handshake;
    logic             load_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dump_sel   = 1'b0;
        dump_a     = '0;
        done       = 1'b0;
        out_valid  = 1'b0;
        load_out   = 1'b0;
        halt_seen  = (state == ST_RUN) && (instruction_memory_rd == HALT_WORD);
        handshake  = out_valid_q && out_ready;
        case (state)
            ST_RUN: begin
                if (halt_seen) begin
                    state_next = (DRAIN_CYCLES == 0) ? ST_DUMP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 32'd0) begin
                    state_next = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_sel  = 1'b1;
                dump_a    = {rd_idx[IDX_W-3:0], 2'b00};
                out_valid = out_valid_q;
                load_out  = (rd_idx < MEM_END) && (!out_valid_q || out_ready);
                if ((rd_idx == MEM_END) && !out_valid_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // One-entry output hold stage: a new word is captured only when the slot
    // is empty or being drained on this edge, so stalls freeze index and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt   <= 32'd0;
            rd_idx      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= 32'd0;
            halted_q    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_seen) begin
                        halted_q  <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                        rd_idx    <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != 32'd0) begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                ST_DUMP: begin
                    if (load_out) begin
                        out_data_q  <= data_memory_rd;
                        out_index_q <= rd_idx[IDX_W-1:0];
                        out_valid_q <= 1'b1;
                        rd_idx      <= rd_idx + (IDX_W+1)'(1);
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_halt_dump_controller.sv
// Randomised bench for halt_dump_controller: three instances with different
// depth/drain settings, checked edge by edge against a precomputed word schedule.
module tb_halt_dump_controller;

    function automatic int mw_of(input int g);
        return (g == 2) ? 1 : 4;
    endfunction

    function automatic int dc_of(input int g);
        return (g == 0) ? 3 : ((g == 1) ? 0 : 2);
    endfunction

    logic        clk;
    logic        rst_n     [3];
    logic [31:0] instr     [3];
    logic [31:0] dump_a    [3];
    logic        dump_sel  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_index [3];
    logic [31:0] out_data  [3];
    logic        halted    [3];
    logic        done      [3];
    logic [31:0] mem       [3][4];

    int nchecks = 0;
    int nerrors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        logic [31:0] rd_word;
        assign rd_word = mem[g][dump_a[g][3:2]];

        halt_dump_controller #(
            .MEM_WORDS(mw_of(g)),
            .DRAIN_CYCLES(dc_of(g)),
            .IDX_W(32)
        ) dut (
            .clk(clk),
            .rst_n(rst_n[g]),
            .instruction_memory_rd(instr[g]),
            .dump_a(dump_a[g]),
            .dump_sel(dump_sel[g]),
            .data_memory_rd(rd_word),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_index(out_index[g]),
            .out_data(out_data[g]),
            .halted(halted[g]),
            .done(done[g])
        );
    end

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            nchecks++;
            if ({halted[g], dump_sel[g], done[g], out_valid[g]} !== 4'b0000) begin
                nerrors++;
                $display("[TB] FAIL reset_flags dut%0d got %b want 0000", g,
                         {halted[g], dump_sel[g], done[g], out_valid[g]});
            end
            nchecks++;
            if ({dump_a[g], out_index[g], out_data[g]} !== 96'd0) begin
                nerrors++;
                $display("[TB] FAIL reset_buses dut%0d got a=%h idx=%h data=%h want all 0",
                         g, dump_a[g], out_index[g], out_data[g]);
            end
        end
    endtask

    // Word k becomes presentable at edge load_e[k] and is accepted at the first
    // later edge whose ready is high; the next word loads on that same edge.
    task automatic test_dump_sequence(input int g, input int h, input int mode,
                                      input bit bounce, input string name);
        int mw, dc, ld, e, last, nl, kv;
        int load_e[4];
        int acc_e[4];
        bit rdy[256];
        logic [3:0]  exp_flags;
        logic [31:0] exp_a;
        mw = mw_of(g);
        dc = dc_of(g);
        for (int i = 0; i < 4; i++) mem[g][i] = $urandom;
        for (int i = 0; i < 256; i++) rdy[i] = (mode == 1 && i < 200) ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mode == 2) for (int i = h + dc + 3; i <= h + dc + 7; i++) rdy[i] = 1'b0;
        ld = h + dc + 1;
        for (int k = 0; k < mw; k++) begin
            load_e[k] = ld;
            e = ld + 1;
            while (!rdy[e]) e++;
            acc_e[k] = e;
            ld = e;
        end
        last = acc_e[mw-1] + 3;

        rst_n[g] = 1'b0;
        out_ready[g] = 1'b0;
        instr[g] = 32'h1;
        @(posedge clk);
        #1;
        rst_n[g] = 1'b1;
        for (int ed = 1; ed <= last; ed++) begin
            instr[g] = (ed < h) ? ($urandom | 32'h1) : ((ed == h) ? 32'h0 : (bounce ? $urandom : 32'h0));
            out_ready[g] = rdy[ed];
            @(posedge clk);
            #1;
            nl = 0;
            kv = -1;
            for (int k = 0; k < mw; k++) begin
                if (load_e[k] <= ed) nl++;
                if (load_e[k] <= ed && ed < acc_e[k]) kv = k;
            end
            exp_flags[3] = (ed >= h);
            exp_flags[2] = (ed >= h + dc) && (ed <= acc_e[mw-1]);
            exp_flags[1] = (ed > acc_e[mw-1]);
            exp_flags[0] = (kv >= 0);
            exp_a = exp_flags[2] ? 32'(4 * nl) : 32'd0;
            nchecks++;
            if ({halted[g], dump_sel[g], done[g], out_valid[g]} !== exp_flags) begin
                nerrors++;
                $display("[TB] FAIL %s flags edge %0d got h/sel/done/v=%b want %b", name, ed,
                         {halted[g], dump_sel[g], done[g], out_valid[g]}, exp_flags);
            end
            nchecks++;
            if (dump_a[g] !== exp_a) begin
                nerrors++;
                $display("[TB] FAIL %s dump_a edge %0d got %0d want %0d", name, ed, dump_a[g], exp_a);
            end
            if (kv >= 0) begin
                nchecks++;
                if (out_index[g] !== 32'(kv) || out_data[g] !== mem[g][kv]) begin
                    nerrors++;
                    $display("[TB] FAIL %s word edge %0d got (%0d,%h) want (%0d,%h)", name, ed,
                             out_index[g], out_data[g], kv, mem[g][kv]);
                end
            end
        end
        rst_n[g] = 1'b0;
        out_ready[g] = 1'b0;
    endtask

    task automatic test_full_throughput();
        test_dump_sequence(0, 10, 0, 1'b0, "full_rate");
    endtask

    task automatic test_backpressure();
        test_dump_sequence(0, 6, 2, 1'b0, "stall_word1");
    endtask

    task automatic test_zero_drain();
        test_dump_sequence(1, 4, 0, 1'b0, "zero_drain");
    endtask

    task automatic test_drain_ignore();
        test_dump_sequence(0, 5, 0, 1'b1, "drain_ignore");
    endtask

    task automatic test_single_word();
        test_dump_sequence(2, 3, 1, 1'b1, "single_word");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) mem[0][i] = $urandom;
        rst_n[0] = 1'b0;
        instr[0] = 32'h1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        // Halt at edge 3, drain 3 -> words 0 and 1 accepted at edges 8 and 9.
        for (int ed = 1; ed <= 9; ed++) begin
            instr[0] = (ed == 3) ? 32'h0 : 32'h5;
            @(posedge clk);
            #1;
        end
        nchecks++;
        if (out_valid[0] !== 1'b1 || out_index[0] !== 32'd2) begin
            nerrors++;
            $display("[TB] FAIL mid_reset_pre got v=%b idx=%0d want v=1 idx=2", out_valid[0], out_index[0]);
        end
        #2;
        rst_n[0] = 1'b0;
        #1;
        nchecks++;
        if ({halted[0], dump_sel[0], done[0], out_valid[0]} !== 4'b0000 ||
            {dump_a[0], out_index[0], out_data[0]} !== 96'd0) begin
            nerrors++;
            $display("[TB] FAIL mid_reset_async got flags=%b a=%h idx=%h data=%h want all 0",
                     {halted[0], dump_sel[0], done[0], out_valid[0]}, dump_a[0], out_index[0], out_data[0]);
        end
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        for (int ed = 1; ed <= 6; ed++) begin
            instr[0] = $urandom | 32'h1;
            @(posedge clk);
            #1;
            nchecks++;
            if ({halted[0], dump_sel[0], done[0], out_valid[0]} !== 4'b0000) begin
                nerrors++;
                $display("[TB] FAIL mid_reset_after edge %0d got %b want 0000", ed,
                         {halted[0], dump_sel[0], done[0], out_valid[0]});
            end
        end
        instr[0] = 32'h0;
        @(posedge clk);
        #1;
        nchecks++;
        if ({halted[0], dump_sel[0]} !== 2'b10) begin
            nerrors++;
            $display("[TB] FAIL mid_reset_rehalt got halted/sel=%b want 10", {halted[0], dump_sel[0]});
        end
        rst_n[0] = 1'b0;
    endtask

    task automatic test_random();
        int g;
        for (int r = 0; r < 6; r++) begin
            g = $urandom_range(0, 2);
            test_dump_sequence(g, $urandom_range(2, 10), $urandom_range(0, 1),
                               1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            instr[g] = 32'h1;
            out_ready[g] = 1'b0;
            for (int i = 0; i < 4; i++) mem[g][i] = 32'd0;
        end
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_zero_drain();
        test_drain_ignore();
        test_mid_reset();
        test_single_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

endmodule
